// File: rtl/rr_sel_sequencer_if.sv
// Handshake bundle between a request/consume source and the round-robin
// select sequencer that steers a downstream 4:1 mux.
interface rr_sel_sequencer_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       valid;
  logic [3:0] grant;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  sel,
    input  valid,
    input  grant,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output valid,
    output grant,
    output timeout
  );
endinterface

// File: rtl/rr_sel_sequencer.sv
// Round-robin select sequencer: picks one requesting channel at a time for
// a downstream 4:1 mux, holds it for at most DWELL cycles, and always
// inserts one idle gap cycle between consecutive grants.
module rr_sel_sequencer #(
  parameter int DWELL = 4
) (
  input logic             clk,
  input logic             rst_n,
  rr_sel_sequencer_if.slave bus
);

  localparam int CW = $clog2(DWELL);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    sel_q;
  logic [1:0]    win;
  logic [CW-1:0] cnt;
  logic          valid_q;
  logic          timeout_q;
  logic [3:0]    grant_q;
  logic          at_limit;
  logic          still_req;
  logic          exit_grant;

  // Search starting just after the last winner; scanning from the far end
  // lets the nearest set bit overwrite the others.
  always_comb begin
    win = ptr;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[2'(ptr + 2'(k))]) begin
        win = 2'(ptr + 2'(k));
      end
    end
  end

  assign at_limit   = (cnt == CW'(DWELL - 1));
  assign still_req  = bus.req[sel_q];
  assign exit_grant = bus.done | ~still_req | at_limit;

  // Grant sequencer: all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'b11;
      sel_q     <= 2'b00;
      cnt       <= '0;
      valid_q   <= 1'b0;
      grant_q   <= 4'b0000;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          timeout_q <= 1'b0;
          if (|bus.req) begin
            state   <= GRANT;
            sel_q   <= win;
            ptr     <= win;
            cnt     <= '0;
            valid_q <= 1'b1;
            grant_q <= 4'b0001 << win;
          end else begin
            state   <= IDLE;
            valid_q <= 1'b0;
            grant_q <= 4'b0000;
          end
        end
        GRANT: begin
          if (exit_grant) begin
            state     <= GAP;
            valid_q   <= 1'b0;
            grant_q   <= 4'b0000;
            timeout_q <= at_limit & ~bus.done & still_req;
          end else begin
            cnt       <= cnt + CW'(1);
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          valid_q   <= 1'b0;
          grant_q   <= 4'b0000;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.valid   = valid_q;
  assign bus.grant   = grant_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Self-checking bench for rr_sel_sequencer: directed scenarios followed by
// randomized traffic, all compared against a channel-level reference model.
module tb_rr_sel_sequencer;

  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst_n;

  rr_sel_sequencer_if bus ();

  rr_sel_sequencer #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the channel currently being served (-1 if none),
  // how many cycles it has been served, and the last channel served.
  int m_ch;
  int m_used;
  int m_last;
  int m_sel;
  bit m_timeout;

  logic [1:0] sel_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic modelReset();
    m_ch      = -1;
    m_used    = 0;
    m_last    = 3;
    m_sel     = 0;
    m_timeout = 0;
  endtask

  // One clock edge of the reference behaviour, given the inputs seen there.
  task automatic modelEdge(input logic [3:0] r, input logic d);
    int served;
    int c;
    m_timeout = 0;
    if (m_ch >= 0) begin
      served = m_used + 1;
      if (d || !r[m_ch] || served == DWELL) begin
        m_timeout = (served == DWELL) && !d && r[m_ch];
        m_ch = -1;
      end else begin
        m_used = served;
      end
    end else if (r != 4'b0000) begin
      for (int off = 4; off >= 1; off--) begin
        c = (m_last + off) % 4;
        if (r[c]) m_ch = c;
      end
      m_last = m_ch;
      m_sel  = m_ch;
      m_used = 0;
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, " valid"},   32'(bus.valid),   32'(m_ch >= 0));
    checkOutput({tag, " sel"},     32'(bus.sel),     32'(m_sel));
    checkOutput({tag, " grant"},   32'(bus.grant),   (m_ch >= 0) ? (32'd1 << m_sel) : 32'd0);
    checkOutput({tag, " timeout"}, 32'(bus.timeout), 32'(m_timeout));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " sel"},     32'(bus.sel),     32'd0);
    checkOutput({tag, " valid"},   32'(bus.valid),   32'd0);
    checkOutput({tag, " grant"},   32'(bus.grant),   32'd0);
    checkOutput({tag, " timeout"}, 32'(bus.timeout), 32'd0);
  endtask

  task automatic stepCycle(input string tag, input logic [3:0] r, input logic d);
    applyStimulus(r, d);
    @(posedge clk);
    modelEdge(r, d);
    #1;
    checkAgainstModel(tag);
    if (bus.valid === 1'b1) sel_log.push_back(bus.sel);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [1:0] exp_seq [5];
    logic [5:0] vpat;
    logic [5:0] tpat;
    logic [3:0] r;
    logic       d;

    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
    exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;

    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;

    // All channels requesting, done one cycle into each grant.
    sel_log.delete();
    for (int i = 0; i < 10; i++) stepCycle("rr4", 4'b1111, m_ch >= 0);
    checkOutput("rr4 count", 32'(sel_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < sel_log.size(); i++)
      checkOutput("rr4 order", 32'(sel_log[i]), 32'(exp_seq[i]));
    stepCycle("drain", 4'b0000, 1'b0);

    // Single holder runs into dwell expiry, then is regranted.
    for (int i = 0; i < 6; i++) begin
      stepCycle("dwell", 4'b0100, 1'b0);
      vpat[i] = bus.valid;
      tpat[i] = bus.timeout;
    end
    checkOutput("dwell valid pattern", 32'(vpat), 32'(6'b101111));
    checkOutput("dwell timeout pattern", 32'(tpat), 32'(6'b010000));
    checkOutput("dwell regrant sel", 32'(bus.sel), 32'd2);
    stepCycle("drain", 4'b0000, 1'b0);
    stepCycle("drain", 4'b0000, 1'b0);

    // Request withdrawn mid-grant.
    stepCycle("drop", 4'b0010, 1'b0);
    stepCycle("drop", 4'b0010, 1'b0);
    stepCycle("drop", 4'b0000, 1'b0);
    checkOutput("drop no timeout", 32'(bus.timeout), 32'd0);
    stepCycle("drop", 4'b0000, 1'b0);
    checkOutput("drop idle grant", 32'(bus.grant), 32'd0);

    // done coinciding with the last dwell cycle suppresses timeout.
    for (int i = 0; i < 4; i++) stepCycle("lastdone", 4'b0001, 1'b0);
    stepCycle("lastdone", 4'b0001, 1'b1);
    checkOutput("lastdone timeout", 32'(bus.timeout), 32'd0);
    stepCycle("drain", 4'b0000, 1'b0);

    // Wrap-around from channel 3 to channel 0 and back.
    stepCycle("wrap", 4'b1000, 1'b0);
    stepCycle("wrap", 4'b0000, 1'b0);
    stepCycle("wrap", 4'b1001, 1'b0);
    checkOutput("wrap first", 32'(bus.sel), 32'd0);
    stepCycle("wrap", 4'b1001, 1'b1);
    stepCycle("wrap", 4'b1001, 1'b0);
    checkOutput("wrap second", 32'(bus.sel), 32'd3);
    stepCycle("drain", 4'b0000, 1'b0);
    stepCycle("drain", 4'b0000, 1'b0);

    // Asynchronous reset in the middle of a grant.
    stepCycle("midrst", 4'b0100, 1'b0);
    stepCycle("midrst", 4'b0100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midrst async");
    modelReset();
    @(posedge clk);
    #1;
    checkResetValues("midrst held");
    rst_n = 1'b1;
    stepCycle("midrst regrant", 4'b0100, 1'b0);
    checkOutput("midrst regrant sel", 32'(bus.sel), 32'd2);

    // Randomized traffic with requests that tend to persist.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 5) == 0);
      stepCycle("rand", r, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
